// File: rtl/arb_pkg.sv
// Shared types, sizes, reset values and the rotating-priority pick function
// for the four-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic [IDX_W-1:0] GNT_IDX_RST = '0;
  localparam logic [IDX_W-1:0] PTR_RST     = '0;

  // Scans ptr, ptr+1, ... (mod N_REQ); the nearest asserted request wins.
  // Result is meaningless when req is all-zero; callers gate on |req.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/onehot_dec2.sv
// Combinational 2-bit index to 4-bit one-hot decoder with enable;
// en_i=0 forces an all-zero output.
module onehot_dec2
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with per-grant hold limit; defining
// ARB_LOCK_EN adds a lock input that suppresses the hold-limit timeout.
// State | meaning: IDLE | no grant, arbitrate on req ; GRANT | gnt_idx owns the resource
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_valid_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [IDX_W-1:0] winner_d;
  logic             hold_at_max;
  logic             hold_ext;

  assign winner_d    = rr_pick(req, ptr_q);
  assign hold_at_max = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

`ifdef ARB_LOCK_EN
  assign hold_ext = lock;
`else
  assign hold_ext = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_idx_q   <= GNT_IDX_RST;
      gnt_valid_q <= 1'b0;
      ptr_q       <= PTR_RST;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_idx_q   <= winner_d;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_idx_q] || (hold_at_max && !hold_ext)) begin
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + 1'b1;
            state_q     <= IDLE;
          end else if (!hold_at_max) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
          // locked at the limit: counter saturates, grant stays
        end
        default: begin
          gnt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  onehot_dec2 u_dec (
    .idx_i    (gnt_idx_q),
    .en_i     (gnt_valid_q),
    .onehot_o (gnt)
  );

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: four instances with MAX_HOLD of 8, 4, 1 and 2
// share clock and reset; each task drives one scenario and checks inline.
module tb_rr_arbiter4;

  logic clk;
  logic rst;
  logic [3:0] req_a, req_b, req_c, req_d;
  logic       lock_d;
  logic [3:0] gnt_a, gnt_b, gnt_c, gnt_d;
  logic [1:0] idx_a, idx_b, idx_c, idx_d;
  logic       val_a, val_b, val_c, val_d;

  int vectors = 0;
  int errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a));

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b));

  rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .req(req_c),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c));

  rr_arbiter4 #(.MAX_HOLD(2), .CNT_W(8)) dut_d (
    .clk(clk), .rst(rst), .req(req_d),
`ifdef ARB_LOCK_EN
    .lock(lock_d),
`endif
    .gnt(gnt_d), .gnt_idx(idx_d), .gnt_valid(val_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    lock_d = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (gnt_a !== 4'b0000 || val_a !== 1'b0 || idx_a !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got gnt=%b valid=%b idx=%0d, want 0000/0/0",
                 i, gnt_a, val_a, idx_a);
      end
    end
    req_a = 4'b0001;
    tick();
    vectors++;
    if (gnt_a !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pre_grant: got gnt=%b, want 0001", gnt_a);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (gnt_a !== 4'b0000 || val_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_mid_grant: got gnt=%b valid=%b, want 0000/0", gnt_a, val_a);
    end
    req_a = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    do_reset();
    req_a = 4'b1010;
    tick();
    vectors++;
    if (gnt_a !== 4'b0010 || idx_a !== 2'd1) begin
      errors++;
      $display("FAIL rot_first: got gnt=%b idx=%0d, want 0010/1", gnt_a, idx_a);
    end
    req_a = 4'b1000;
    tick();
    vectors++;
    if (gnt_a !== 4'b0000 || val_a !== 1'b0) begin
      errors++;
      $display("FAIL rot_dead: got gnt=%b valid=%b, want 0000/0", gnt_a, val_a);
    end
    tick();
    vectors++;
    if (gnt_a !== 4'b1000 || idx_a !== 2'd3) begin
      errors++;
      $display("FAIL rot_second: got gnt=%b idx=%0d, want 1000/3", gnt_a, idx_a);
    end
    req_a = 4'b0000;
    tick();
    vectors++;
    if (gnt_a !== 4'b0000 || idx_a !== 2'd3) begin
      errors++;
      $display("FAIL rot_release_idx_kept: got gnt=%b idx=%0d, want 0000/3", gnt_a, idx_a);
    end
    req_a = 4'b1111;
    tick();
    vectors++;
    if (gnt_a !== 4'b0001 || idx_a !== 2'd0) begin
      errors++;
      $display("FAIL rot_wrap: got gnt=%b idx=%0d, want 0001/0", gnt_a, idx_a);
    end
    req_a = 4'b0000;
    tick();
  endtask

  task automatic test_hold_single();
    logic [3:0] exp_seq [0:9];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    do_reset();
    req_b = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (gnt_b !== exp_seq[i]) begin
        errors++;
        $display("FAIL hold_single cyc%0d: got gnt=%b, want %b", i, gnt_b, exp_seq[i]);
      end
    end
    req_b = 4'b0000;
    tick();
  endtask

  task automatic test_hold_pair();
    logic [3:0] exp_seq [0:14];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    do_reset();
    req_b = 4'b0011;
    for (int i = 0; i < 15; i++) begin
      tick();
      vectors++;
      if (gnt_b !== exp_seq[i]) begin
        errors++;
        $display("FAIL hold_pair cyc%0d: got gnt=%b, want %b", i, gnt_b, exp_seq[i]);
      end
    end
    req_b = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [0:8];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req_c = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if (gnt_c !== exp_seq[i]) begin
        errors++;
        $display("FAIL b2b_hold1 cyc%0d: got gnt=%b, want %b", i, gnt_c, exp_seq[i]);
      end
    end
    req_c = 4'b0000;
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    req_d  = 4'b0101;
    lock_d = 1'b1;
`ifdef ARB_LOCK_EN
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (gnt_d !== 4'b0001) begin
        errors++;
        $display("FAIL lock_hold cyc%0d: got gnt=%b, want 0001", i, gnt_d);
      end
    end
    lock_d = 1'b0;
    tick();
    vectors++;
    if (gnt_d !== 4'b0000) begin
      errors++;
      $display("FAIL lock_release: got gnt=%b, want 0000", gnt_d);
    end
    tick();
    vectors++;
    if (gnt_d !== 4'b0100 || idx_d !== 2'd2) begin
      errors++;
      $display("FAIL lock_next: got gnt=%b idx=%0d, want 0100/2", gnt_d, idx_d);
    end
`else
    begin
      logic [3:0] exp_seq [0:6];
      exp_seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
      for (int i = 0; i < 7; i++) begin
        tick();
        vectors++;
        if (gnt_d !== exp_seq[i]) begin
          errors++;
          $display("FAIL nolock_timeout cyc%0d: got gnt=%b, want %b", i, gnt_d, exp_seq[i]);
        end
      end
    end
`endif
    req_d  = 4'b0000;
    lock_d = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    lock_d = 1'b0;
    test_reset();
    test_rotation();
    test_hold_single();
    test_hold_pair();
    test_back_to_back();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter sharing one 4-way resource between four requesters.
- Selects a 2-bit winner index and drives a one-hot grant through a 2-to-4 one-hot decoder sub-module.
- Grant is held until the owner drops its request or a hold limit expires. Rotating priority guarantees fairness.
- Sits in front of any 4-slot shared datapath (bus, memory port, ALU) whose enables are one-hot.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may last; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  4  request lines; req[i] is requester i.
- gnt  output  4  one-hot grant, all-zero when no grant.
- gnt_idx  output  2  binary index of current/last winner.
- gnt_valid  output  1  high while a grant is active.

Behaviour:
- Reset: state=IDLE, gnt=4'b0000, gnt_valid=0, gnt_idx=2'b00, priority pointer ptr=0, hold_cnt=0. Assertion mid-grant clears gnt immediately (asynchronous).
- All outputs are registered or decoded from registers only. There is no combinational path from req to gnt.
- gnt = decode(gnt_idx) when gnt_valid=1, otherwise 4'b0000.
- States: IDLE, GRANT.
- IDLE: if req!=0, the winner is the first i with req[i]=1 scanning ptr, ptr+1, ... mod 4. At the edge: gnt_idx<=winner, gnt_valid<=1, hold_cnt<=0, go to GRANT. If req==0, stay in IDLE and leave gnt_idx unchanged.
- Latency: req sampled high in IDLE at edge N gives gnt high from edge N onward (visible in cycle N+1).
- GRANT, per edge:
  - If req[gnt_idx]=0: release.
  - Else if hold_cnt==MAX_HOLD-1: release (timeout).
  - Else: hold_cnt<=hold_cnt+1, stay.
- Release: gnt_valid<=0, ptr<=gnt_idx+1 (mod 4, 2-bit wrap 3->0), go to IDLE. This gives exactly one dead cycle between consecutive grants.
- Grant length: MAX_HOLD=1 means every grant lasts one cycle. A held request is never granted more than MAX_HOLD cycles in a row.
- Timed-out requester that keeps req high: competes normally in IDLE with lowest priority. It is regranted after one dead cycle if it is the only requester.
- Changes on non-granted req lines during GRANT are ignored until IDLE.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While in GRANT with lock=1 and req[gnt_idx]=1, the timeout is suppressed and hold_cnt saturates at MAX_HOLD-1.
  - Dropping req still releases.
  - lock is ignored in IDLE.
- Undefined: no lock port; timeout always applies.

Decomposition:
- Shared package arb_pkg:
  - state typedef (IDLE, GRANT).
  - N_REQ=4, IDX_W=2.
  - Reset constants for gnt_idx and ptr.
- One sub-module, onehot_dec2:
  - Purely combinational 2-bit index to 4-bit one-hot with enable input.
  - Enable=0 gives 4'b0000.
  - Instantiated once for gnt.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0, gnt_idx=00 throughout. Assert rst during a grant -> gnt=0000 in the same cycle.
- req=4'b1010 from reset (ptr=0) -> gnt=0010 (idx 1). Drop req[1] -> one cycle gnt=0000, then gnt=1000 (idx 3). Next idle arbitration with req=4'b1111 -> gnt=0001 (ptr wrapped to 0).
- MAX_HOLD=4, req=4'b0001 held constantly -> gnt=0001 for exactly 4 cycles, 0000 for 1 cycle, repeating.
- MAX_HOLD=4, req=4'b0011 held constantly -> grants alternate 0001 (4 cycles), gap, 0010 (4 cycles), gap; no requester starves.
- MAX_HOLD=1, req=4'b1111 -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- ARB_LOCK_EN, MAX_HOLD=2, req=4'b0101, lock=1 for 10 cycles -> gnt=0001 held 10+ cycles. Lock drops -> release within 1 cycle, then gnt=0100 after one dead cycle. Without the macro, the same stimulus times out after 2 cycles.
